// File: rtl/dilated_tap_buffer.sv
// Per-channel history ring for dilated causal convolution: keeps the last (K-1)*D+1
// accepted C-channel vectors and presents K taps spaced D samples apart, oldest first.
module dilated_tap_buffer #(
    parameter int W = 16,
    parameter int C = 1,
    parameter int K = 4,
    parameter int D = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [C*W-1:0]     in_data,
    input  logic               clear,
    output logic               out_valid,
    output logic [K*C*W-1:0]   out_taps,
    output logic               primed
);
    localparam int DEPTH = (K - 1) * D + 1;
    localparam int VW    = C * W;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [VW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [K*VW-1:0]  taps_q, taps_d;
    logic             out_valid_q;
    logic             primed_q, primed_d;
    logic             accept;

    assign accept = in_valid & ~clear;

    always_comb begin
        int rd;
        rd       = 0;
        wp_d     = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
        cnt_d    = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
        primed_d = (cnt_q >= CW'(DEPTH - 1));
        taps_d   = '0;
        taps_d[(K-1)*VW +: VW] = in_data;
        // Older taps are read before this edge's write; offset < DEPTH, so one wrap suffices.
        for (int k = 0; k < K - 1; k++) begin
            if (int'(wp_q) >= (K - 1 - k) * D)
                rd = int'(wp_q) - (K - 1 - k) * D;
            else
                rd = int'(wp_q) + DEPTH - (K - 1 - k) * D;
            taps_d[k*VW +: VW] = mem_q[PW'(rd)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q        <= '0;
            cnt_q       <= '0;
            taps_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q        <= '0;
            cnt_q       <= '0;
            taps_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            mem_q[wp_q] <= in_data;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            taps_q      <= taps_d;
            primed_q    <= primed_d;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_taps  = taps_q;
    assign primed    = primed_q;
endmodule

// File: tb/tb_dilated_tap_buffer.sv
// Bench for dilated_tap_buffer: a K=4,D=1,C=1 instance and a K=4,D=2,C=2 instance,
// checked against constants and a queue-based history model.
module tb_dilated_tap_buffer;
    logic clk;
    logic rst_n;

    logic        a_in_valid, a_clear, a_out_valid, a_primed;
    logic [15:0] a_in_data;
    logic [63:0] a_out_taps;

    logic         b_in_valid, b_clear, b_out_valid, b_primed;
    logic [31:0]  b_in_data;
    logic [127:0] b_out_taps;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hist [$];

    dilated_tap_buffer #(.W(16), .C(1), .K(4), .D(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .clear(a_clear), .out_valid(a_out_valid), .out_taps(a_out_taps), .primed(a_primed)
    );

    dilated_tap_buffer #(.W(16), .C(2), .K(4), .D(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .clear(b_clear), .out_valid(b_out_valid), .out_taps(b_out_taps), .primed(b_primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Taps for the D=2 instance straight from the accepted-sample history.
    function automatic logic [127:0] model_taps();
        logic [127:0] t;
        int j;
        t = '0;
        for (int k = 0; k < 4; k++) begin
            j = hist.size() - 1 - (3 - k) * 2;
            if (j >= 0) t[k*32 +: 32] = hist[j];
        end
        return t;
    endfunction

    function automatic logic [31:0] vec_b(input int n);
        logic [15:0] p, m;
        p = 16'(n);
        m = 16'(-n);
        return {m, p};
    endfunction

    function automatic logic [127:0] taps_b(input int t0, input int t1, input int t2, input int t3);
        return {vec_b(t3), vec_b(t2), vec_b(t1), vec_b(t0)};
    endfunction

    task automatic cyc_b(input logic v, input logic clr, input logic [31:0] d, input string tag);
        b_in_valid = v;
        b_clear    = clr;
        b_in_data  = d;
        @(posedge clk);
        if (clr) hist.delete();
        else if (v) hist.push_back(d);
        @(negedge clk);
        chk({tag, ".valid"},  128'(b_out_valid), 128'(v && !clr));
        chk({tag, ".taps"},   b_out_taps, model_taps());
        chk({tag, ".primed"}, 128'(b_primed), 128'(hist.size() >= 7));
        b_in_valid = 1'b0;
        b_clear    = 1'b0;
    endtask

    task automatic cyc_a(input logic [15:0] d, input logic [63:0] exp_taps, input logic exp_primed,
                         input string tag);
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".valid"},  128'(a_out_valid), 128'(1));
        chk({tag, ".taps"},   128'(a_out_taps), 128'(exp_taps));
        chk({tag, ".primed"}, 128'(a_primed), 128'(exp_primed));
        a_in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_clear = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_clear = 1'b0; b_in_data = '0;
        #12;
        chk("rst.a_taps",   128'(a_out_taps), 128'(0));
        chk("rst.a_valid",  128'(a_out_valid), 128'(0));
        chk("rst.b_taps",   b_out_taps, 128'(0));
        chk("rst.b_primed", 128'(b_primed), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // K=4, D=1 directed sequence, then signed extremes
        cyc_a(16'd5, 64'h0005_0000_0000_0000, 1'b0, "a1");
        cyc_a(16'd6, 64'h0006_0005_0000_0000, 1'b0, "a2");
        cyc_a(16'd7, 64'h0007_0006_0005_0000, 1'b0, "a3");
        cyc_a(16'd8, 64'h0008_0007_0006_0005, 1'b1, "a4");
        cyc_a(16'h8000, 64'h8000_0008_0007_0006, 1'b1, "a_min");
        cyc_a(16'h7FFF, 64'h7FFF_8000_0008_0007, 1'b1, "a_max");
        @(negedge clk);
        chk("a_gap.valid", 128'(a_out_valid), 128'(0));
        chk("a_gap.taps",  128'(a_out_taps), 128'(64'h7FFF_8000_0008_0007));

        // K=4, D=2, C=2 ramp: ch0=n, ch1=-n
        for (int n = 1; n <= 10; n++) begin
            cyc_b(1'b1, 1'b0, vec_b(n), $sformatf("ramp%0d", n));
            if (n == 6)  chk("ramp6.unprimed", 128'(b_primed), 128'(0));
            if (n == 7)  chk("ramp7.const",  b_out_taps, taps_b(1, 3, 5, 7));
            if (n == 8)  chk("ramp8.const",  b_out_taps, taps_b(2, 4, 6, 8));
            if (n == 10) chk("ramp10.const", b_out_taps, taps_b(4, 6, 8, 10));
        end

        // clear wins over a simultaneous accept
        cyc_b(1'b1, 1'b1, vec_b(99), "clear");
        cyc_b(1'b1, 1'b0, vec_b(42), "post_clear");
        chk("post_clear.const", b_out_taps, taps_b(0, 0, 0, 42) & {32'hFFFF_FFFF, 96'h0});

        // random stalls and data, well past five ring wraps
        acc = 0;
        for (int i = 0; i < 400 && acc < 40; i++) begin
            logic v;
            v = ($urandom_range(0, 2) != 0);
            if (v) acc++;
            cyc_b(v, 1'b0, $urandom, $sformatf("rnd%0d", i));
        end
        chk("rnd.count", 128'(acc), 128'(40));

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.b_taps",   b_out_taps, 128'(0));
        chk("arst.b_primed", 128'(b_primed), 128'(0));
        chk("arst.a_taps",   128'(a_out_taps), 128'(0));
        chk("arst.a_valid",  128'(a_out_valid), 128'(0));
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc_b(1'b1, 1'b0, vec_b(-3), "after_rst");
        chk("after_rst.const", b_out_taps, {vec_b(-3), 96'h0});
        cyc_a(16'd9, 64'h0009_0000_0000_0000, 1'b0, "a_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
